// File: rtl/cam_pkg.sv
// Shared definitions for the camera pattern generator: pattern modes, FSM states,
// the colour-bar table and RGB444 byte-packing helpers.
package cam_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID    = 2'd0,
        MODE_BARS     = 2'd1,
        MODE_CHECKER  = 2'd2,
        MODE_GRADIENT = 2'd3
    } cam_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } cam_state_t;

    // Entry 0 is the leftmost bar.
    localparam logic [7:0][11:0] BAR_COLORS = {
        12'h000, 12'h00F, 12'hF00, 12'hF0F,
        12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
    };

    function automatic logic [11:0] pack_rgb(input logic [3:0] r,
                                             input logic [3:0] g,
                                             input logic [3:0] b);
        return {r, g, b};
    endfunction

    // Even byte carries red in the low nibble, odd byte carries {G,B}.
    function automatic logic [7:0] rgb_byte(input logic [11:0] rgb, input logic odd);
        return odd ? rgb[7:0] : {4'h0, rgb[11:8]};
    endfunction

endpackage

// File: rtl/cam_pattern_lut.sv
// Combinational pixel colour generator: maps pattern mode and pixel coordinates
// to a 12-bit RGB444 value.
module cam_pattern_lut
    import cam_pkg::*;
#(
    parameter int WIDTH    = 160,
    parameter int CHK_LOG2 = 3,
    parameter int XW       = 8,
    parameter int YW       = 7
) (
    input  logic [1:0]    mode,
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [11:0]   color,
    input  logic [3:0]    frame_cnt,
    output logic [11:0]   rgb
);

    localparam int BAR_W = WIDTH / 8;

    logic [2:0] bar;
    logic       checker_odd;

    always_comb begin
        bar         = 3'(x / XW'(BAR_W));
        checker_odd = (|((x >> CHK_LOG2) & XW'(1))) ^ (|((y >> CHK_LOG2) & YW'(1)));
        rgb         = color;
        case (cam_mode_t'(mode))
            MODE_SOLID:    rgb = color;
            MODE_BARS:     rgb = BAR_COLORS[bar];
            MODE_CHECKER:  rgb = checker_odd ? ~color : color;
            MODE_GRADIENT: rgb = pack_rgb(x[3:0], y[3:0], frame_cnt);
            default:       rgb = color;
        endcase
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// Emulated camera source: divided pixel clock, vsync/href framing and a two-byte
// RGB444 pixel stream, all advancing on the falling edge of the emulated pclk.
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 120,
    parameter int H_BLANK    = 4,
    parameter int V_BLANK    = 4,
    parameter int VSYNC_ROWS = 2,
    parameter int PCLK_DIV   = 2,
    parameter int CHK_LOG2   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  mode,
    input  logic [11:0] color,
    output logic        CAM_pclk,
    output logic        CAM_vsync,
    output logic        CAM_href,
    output logic [7:0]  CAM_px_data,
    output logic        frame_done,
    output logic [3:0]  frame_cnt
);

    localparam int LINE_BYTES = 2 * WIDTH + H_BLANK;
    localparam int ROWS       = V_BLANK + HEIGHT;
    localparam int BW         = $clog2(LINE_BYTES + 1);
    localparam int RW         = $clog2(ROWS + 1);
    localparam int XW         = ($clog2(WIDTH) > 4) ? $clog2(WIDTH) : 4;
    localparam int YW         = ($clog2(HEIGHT) > 4) ? $clog2(HEIGHT) : 4;
    localparam int DW         = (PCLK_DIV > 1) ? $clog2(PCLK_DIV) : 1;

    localparam logic [BW-1:0] BYTE_LAST    = BW'(LINE_BYTES - 1);
    localparam logic [BW-1:0] ACTIVE_BYTES = BW'(2 * WIDTH);
    localparam logic [RW-1:0] ROW_LAST     = RW'(ROWS - 1);
    localparam logic [RW-1:0] VBLANK_ROWS  = RW'(V_BLANK);
    localparam logic [RW-1:0] VSYNC_END    = RW'(VSYNC_ROWS);
    localparam logic [DW-1:0] DIV_LAST     = DW'(PCLK_DIV - 1);

    logic [DW-1:0] div_cnt;
    logic          fall_tick;

    cam_state_t    state, state_next;
    logic [BW-1:0] byte_cnt, byte_next;
    logic [RW-1:0] row_cnt, row_next;
    logic [1:0]    mode_q, mode_next;
    logic [11:0]   color_q, color_next;
    logic [3:0]    frame_cnt_next;
    logic          done_next;

    logic          vsync_next, href_next;
    logic [7:0]    px_next;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;
    logic [11:0]   rgb_next;

    // pclk free-runs in every state; the framing logic only moves on its falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt  <= '0;
            CAM_pclk <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            CAM_pclk <= ~CAM_pclk;
        end else begin
            div_cnt <= div_cnt + DW'(1);
        end
    end

    assign fall_tick = (div_cnt == DIV_LAST) && CAM_pclk;

    always_comb begin
        state_next     = state;
        byte_next      = byte_cnt;
        row_next       = row_cnt;
        mode_next      = mode_q;
        color_next     = color_q;
        frame_cnt_next = frame_cnt;
        done_next      = 1'b0;
        if (fall_tick) begin
            case (state)
                ST_IDLE: begin
                    byte_next = '0;
                    row_next  = '0;
                    if (enable) begin
                        state_next = ST_FRAME;
                        mode_next  = mode;
                        color_next = color;
                    end
                end
                ST_FRAME: begin
                    if (byte_cnt != BYTE_LAST) begin
                        byte_next = byte_cnt + BW'(1);
                    end else begin
                        byte_next = '0;
                        if (row_cnt != ROW_LAST) begin
                            row_next = row_cnt + RW'(1);
                        end else begin
                            // Inputs are only sampled here, so mid-frame changes wait for the next frame.
                            row_next       = '0;
                            done_next      = 1'b1;
                            frame_cnt_next = frame_cnt + 4'd1;
                            if (enable) begin
                                mode_next  = mode;
                                color_next = color;
                            end else begin
                                state_next = ST_IDLE;
                            end
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are computed from the next position so the camera bus comes straight from flops.
    always_comb begin
        vsync_next = (state_next == ST_FRAME) && (row_next < VSYNC_END);
        href_next  = (state_next == ST_FRAME) && (row_next >= VBLANK_ROWS)
                     && (byte_next < ACTIVE_BYTES);
        x_next     = XW'(byte_next >> 1);
        y_next     = YW'(row_next - VBLANK_ROWS);
        px_next    = href_next ? rgb_byte(rgb_next, byte_next[0]) : 8'h00;
    end

    cam_pattern_lut #(
        .WIDTH    (WIDTH),
        .CHK_LOG2 (CHK_LOG2),
        .XW       (XW),
        .YW       (YW)
    ) u_lut (
        .mode      (mode_next),
        .x         (x_next),
        .y         (y_next),
        .color     (color_next),
        .frame_cnt (frame_cnt_next),
        .rgb       (rgb_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            byte_cnt    <= '0;
            row_cnt     <= '0;
            mode_q      <= '0;
            color_q     <= '0;
            frame_cnt   <= '0;
            frame_done  <= 1'b0;
            CAM_vsync   <= 1'b0;
            CAM_href    <= 1'b0;
            CAM_px_data <= '0;
        end else begin
            state       <= state_next;
            byte_cnt    <= byte_next;
            row_cnt     <= row_next;
            mode_q      <= mode_next;
            color_q     <= color_next;
            frame_cnt   <= frame_cnt_next;
            frame_done  <= done_next;
            CAM_vsync   <= vsync_next;
            CAM_href    <= href_next;
            CAM_px_data <= px_next;
        end
    end

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Self-checking bench for cam_pattern_gen: every pclk period of each frame is compared
// against a position-based reference model, with inputs randomly disturbed mid-frame.
module tb_cam_pattern_gen;

    localparam int W     = 16;
    localparam int H     = 6;
    localparam int HB    = 4;
    localparam int VB    = 4;
    localparam int VS    = 2;
    localparam int PD    = 2;
    localparam int CK    = 2;
    localparam int LINE  = 2 * W + HB;
    localparam int ROWS  = VB + H;
    localparam int FL    = LINE * ROWS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  mode;
    logic [11:0] color;
    logic        CAM_pclk;
    logic        CAM_vsync;
    logic        CAM_href;
    logic [7:0]  CAM_px_data;
    logic        frame_done;
    logic [3:0]  frame_cnt;

    int passed = 0;
    int total  = 0;
    int failed = 0;
    int curPos = -1;

    logic [11:0] barTable [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                  12'hF0F, 12'hF00, 12'h00F, 12'h000};

    cam_pattern_gen #(
        .WIDTH(W), .HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB),
        .VSYNC_ROWS(VS), .PCLK_DIV(PD), .CHK_LOG2(CK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .color(color),
        .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
        .CAM_px_data(CAM_px_data), .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s (pos %0d): observed %0h, expected %0h", tag, curPos, obs, exp);
        end
    endtask

    function automatic logic [11:0] refRgb(input int m, input logic [11:0] c, input int fc,
                                           input int x, input int y);
        case (m)
            0:       return c;
            1:       return barTable[x / (W / 8)];
            2:       return ((((x >> CK) ^ (y >> CK)) & 1) == 0) ? c : ~c;
            default: return 12'(((x % 16) << 8) | ((y % 16) << 4) | (fc % 16));
        endcase
    endfunction

    task automatic refOut(input int pos, input int m, input logic [11:0] c, input int fc,
                          output logic vs, output logic hr, output logic [7:0] d);
        int row = pos / LINE;
        int b   = pos % LINE;
        logic [11:0] rgb;
        vs = (row < VS);
        hr = (row >= VB) && (b < 2 * W);
        d  = 8'h00;
        if (hr) begin
            rgb = refRgb(m, c, fc, b / 2, row - VB);
            d   = (b % 2 == 1) ? rgb[7:0] : {4'h0, rgb[11:8]};
        end
    endtask

    task automatic waitFall(output int cycles);
        cycles = 0;
        while (CAM_pclk !== 1'b1 && cycles < 64) begin @(negedge clk); cycles++; end
        while (CAM_pclk !== 1'b0 && cycles < 64) begin @(negedge clk); cycles++; end
        if (cycles >= 64) begin
            total++;
            failed++;
            $display("[TB] FAIL pclk_timeout: no CAM_pclk fall after %0d clk, required %0d", cycles, 2 * PD);
            $fatal(1, "[TB] pclk stalled");
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [1:0] m, input logic [11:0] c);
        enable = en;
        mode   = m;
        color  = c;
    endtask

    // Entered on the sample just after the fall that starts the frame.
    task automatic runFrame(input int fc, input int m, input logic [11:0] c, input int abortAt,
                            input logic nextEn, input logic [1:0] nextM, input logic [11:0] nextC);
        logic vs, hr;
        logic [7:0] d;
        int cyc;
        for (int pos = 0; pos < FL; pos++) begin
            curPos = pos;
            refOut(pos, m, c, fc, vs, hr, d);
            checkOutput("vsync", 32'(CAM_vsync), 32'(vs));
            checkOutput("href", 32'(CAM_href), 32'(hr));
            checkOutput("px_data", 32'(CAM_px_data), 32'(d));
            if (pos == abortAt) return;
            if (pos == FL - 1)
                applyStimulus(nextEn, nextM, nextC);
            else if ($urandom_range(0, 15) == 0)
                applyStimulus(1'($urandom), 2'($urandom), 12'($urandom));
            waitFall(cyc);
            if (pos != 0) checkOutput("pclk_period", 32'(cyc), 32'(2 * PD));
        end
        curPos = -1;
        checkOutput("frame_done_pulse", 32'(frame_done), 32'(1));
        checkOutput("frame_cnt", 32'(frame_cnt), 32'((fc + 1) % 16));
        @(negedge clk);
        checkOutput("frame_done_width", 32'(frame_done), 32'(0));
    endtask

    initial begin
        int cyc;
        int n;
        int rm;
        int nm;
        logic [11:0] rc;
        logic [11:0] nc;
        logic [11:0] gc;

        rst_n = 1'b0;
        applyStimulus(1'b0, 2'd0, 12'h000);
        repeat (3) @(negedge clk);
        checkOutput("rst_pclk", 32'(CAM_pclk), 32'(0));
        checkOutput("rst_vsync", 32'(CAM_vsync), 32'(0));
        checkOutput("rst_href", 32'(CAM_href), 32'(0));
        checkOutput("rst_px_data", 32'(CAM_px_data), 32'(0));
        checkOutput("rst_frame_done", 32'(frame_done), 32'(0));
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'(0));

        rst_n = 1'b1;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (CAM_pclk !== 1'b1 && n < 20);
        checkOutput("first_rise_delay", 32'(n), 32'(PD));

        for (int i = 0; i < 3; i++) begin
            waitFall(cyc);
            if (i > 0) checkOutput("idle_pclk_period", 32'(cyc), 32'(2 * PD));
            checkOutput("idle_vsync", 32'(CAM_vsync), 32'(0));
            checkOutput("idle_href", 32'(CAM_href), 32'(0));
            checkOutput("idle_px_data", 32'(CAM_px_data), 32'(0));
        end

        $display("[TB] directed frames: solid, bars, checkerboard");
        applyStimulus(1'b1, 2'd0, 12'hF00);
        waitFall(cyc);
        rc = 12'($urandom);
        runFrame(0, 0, 12'hF00, -1, 1'b1, 2'd1, rc);
        runFrame(1, 1, rc, -1, 1'b1, 2'd2, 12'h0F0);
        rm = $urandom_range(0, 3);
        rc = 12'($urandom);
        runFrame(2, 2, 12'h0F0, -1, 1'b1, 2'(rm), rc);

        $display("[TB] random frames");
        for (int k = 0; k < 2; k++) begin
            nm = $urandom_range(0, 3);
            nc = 12'($urandom);
            runFrame(3 + k, rm, rc, -1, 1'b1, 2'(nm), nc);
            rm = nm;
            rc = nc;
        end

        $display("[TB] reset mid-frame at row 7, byte 10");
        runFrame(5, rm, rc, 7 * LINE + 10, 1'b1, 2'd0, 12'h000);
        gc = 12'($urandom);
        applyStimulus(1'b1, 2'd3, gc);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pclk", 32'(CAM_pclk), 32'(0));
        checkOutput("midrst_vsync", 32'(CAM_vsync), 32'(0));
        checkOutput("midrst_href", 32'(CAM_href), 32'(0));
        checkOutput("midrst_px_data", 32'(CAM_px_data), 32'(0));
        checkOutput("midrst_frame_done", 32'(frame_done), 32'(0));
        checkOutput("midrst_frame_cnt", 32'(frame_cnt), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        waitFall(cyc);

        $display("[TB] gradient over 17 frames");
        for (int f = 0; f < 17; f++)
            runFrame(f % 16, 3, gc, -1, (f < 16), 2'd3, gc);

        for (int i = 0; i < 3; i++) begin
            waitFall(cyc);
            if (i > 0) checkOutput("end_idle_pclk_period", 32'(cyc), 32'(2 * PD));
            checkOutput("end_idle_vsync", 32'(CAM_vsync), 32'(0));
            checkOutput("end_idle_href", 32'(CAM_href), 32'(0));
            checkOutput("end_idle_px_data", 32'(CAM_px_data), 32'(0));
            checkOutput("end_idle_frame_cnt", 32'(frame_cnt), 32'(1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
